// File: rtl/shift_pkg.sv
// Shared types and constants for the multi-cycle right shifter.
package shift_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_e;

    localparam int unsigned WIDTH_DEFAULT = 64;
    localparam int unsigned SHW           = $clog2(WIDTH_DEFAULT);

    // Encodings of the arith request bit.
    localparam logic LSR = 1'b0;
    localparam logic ASR = 1'b1;

endpackage

// File: rtl/shift_r_seq_if.sv
// Request/response bundle between a requester and the right shifter.
interface shift_r_seq_if #(
    parameter int unsigned WIDTH = 64
);
    localparam int unsigned ShamtW = $clog2(WIDTH);

    logic              start;
    logic [WIDTH-1:0]  in;
    logic [ShamtW-1:0] shamt;
    logic              arith;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  out;

    modport master (
        output start, in, shamt, arith,
        input  busy, done, out
    );

    modport slave (
        input  start, in, shamt, arith,
        output busy, done, out
    );
endinterface

// File: rtl/shift_r_step.sv
// One combinational right-shift step of 0..STEP bits with a selectable fill bit.
module shift_r_step #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned STEP  = 4,
    localparam int unsigned KW   = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] work,
    input  logic [KW-1:0]    k,
    input  logic             fill,
    output logic [WIDTH-1:0] res
);

    // A one-fill is a zero-fill of the inverted word, inverted back.
    always_comb begin
        res = fill ? ~((~work) >> k) : (work >> k);
    end

endmodule

// File: rtl/shift_r_seq.sv
// Multi-cycle 64-bit LSR/ASR unit: shifts up to STEP bits per cycle under a
// start/busy/done handshake, so the datapath needs no right barrel shifter.
module shift_r_seq
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned STEP  = 4
) (
    input logic          clk,
    input logic          reset,
    shift_r_seq_if.slave bus
);

    localparam int unsigned ShamtW = $clog2(WIDTH);
    localparam int unsigned KW     = $clog2(STEP + 1);

    state_e            state_q;
    logic [WIDTH-1:0]  work_q;
    logic [WIDTH-1:0]  out_q;
    logic [ShamtW-1:0] rem_q;
    logic              arith_q;
    logic              busy_q;
    logic              done_q;

    logic [WIDTH-1:0]  step_res;
    logic [KW-1:0]     k;
    logic              fill;
    logic [ShamtW-1:0] shamt_sat;

    // Amounts past WIDTH-1 only exist when WIDTH is not a power of two.
    if ((2 ** ShamtW) > WIDTH) begin : g_sat
        always_comb begin
            shamt_sat = (32'(bus.shamt) > (WIDTH - 1)) ? ShamtW'(WIDTH - 1) : bus.shamt;
        end
    end else begin : g_nosat
        always_comb begin
            shamt_sat = bus.shamt;
        end
    end

    // Step size is min(STEP, remaining); fill comes from the working MSB,
    // which stays equal to the captured sign bit throughout an ASR.
    always_comb begin
        k    = (32'(rem_q) >= STEP) ? KW'(STEP) : KW'(rem_q);
        fill = (arith_q == ASR) && work_q[WIDTH-1];
    end

    shift_r_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .work (work_q),
        .k    (k),
        .fill (fill),
        .res  (step_res)
    );

    // Controller, operand capture, shift counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            work_q  <= '0;
            out_q   <= '0;
            rem_q   <= '0;
            arith_q <= LSR;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // A start seen during the done cycle is dropped.
                    if (bus.start && !done_q) begin
                        work_q  <= bus.in;
                        rem_q   <= shamt_sat;
                        arith_q <= bus.arith;
                        busy_q  <= 1'b1;
                        state_q <= (shamt_sat == '0) ? FINISH : SHIFT;
                    end
                end
                SHIFT: begin
                    work_q <= step_res;
                    rem_q  <= rem_q - ShamtW'(k);
                    if (rem_q == ShamtW'(k)) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    out_q   <= work_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.out  = out_q;

endmodule

// File: tb/tb_shift_r_seq.sv
// Bench for shift_r_seq: expected results are queued at issue and compared at done.
module tb_shift_r_seq;

    typedef struct {
        logic [63:0] res;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    shift_r_seq_if #(.WIDTH(64)) bus ();

    shift_r_seq #(
        .WIDTH (64),
        .STEP  (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [63:0] v, input int sh, input bit ar);
        logic signed [63:0] s;
        s = v;
        if (ar) return s >>> sh;
        return v >> sh;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge; start is left at 'hold' afterwards.
    task automatic issue(input logic [63:0] v, input int sh, input bit ar, input bit hold);
        exp_t e;
        bus.in    = v;
        bus.shamt = 6'(sh);
        bus.arith = ar;
        bus.start = 1'b1;
        e.res = model(v, sh, ar);
        e.lat = 1 + (sh + 3) / 4;
        sb.push_back(e);
        tick();
        bus.start = hold;
    endtask

    task automatic wait_done(output int cyc, output bit seen);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 40) begin
            tick();
            cyc++;
            seen = (bus.done === 1'b1);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.in    = '0;
        bus.shamt = '0;
        bus.arith = 1'b0;
        tick();
        tick();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        total++; if (bus.out !== 64'h0) begin bad++; $display("FAIL reset_out: got %h want 0", bus.out); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_lsr();
        int cyc; bit seen; exp_t e;
        issue(64'h8000_0000_0000_0010, 4, 1'b0, 1'b0);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL lsr_busy: got %b want 1", bus.busy); end
        wait_done(cyc, seen);
        e = sb.pop_front();
        total++; if (!seen || cyc != e.lat) begin bad++; $display("FAIL lsr_lat: got %0d want %0d", cyc, e.lat); end
        total++; if (bus.out !== e.res) begin bad++; $display("FAIL lsr_out: got %h want %h", bus.out, e.res); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL lsr_busy_at_done: got %b want 0", bus.busy); end
        tick();
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL lsr_done_pulse: got %b want 0", bus.done); end
    endtask

    task automatic test_reset_mid();
        int ndone = 0;
        issue(64'hFFFF_0000_0000_0000, 40, 1'b0, 1'b0);
        void'(sb.pop_back());
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rstmid_done: got %b want 0", bus.done); end
        total++; if (bus.out !== 64'h0) begin bad++; $display("FAIL rstmid_out: got %h want 0", bus.out); end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.done === 1'b1) ndone++;
        end
        total++; if (ndone != 0) begin bad++; $display("FAIL rstmid_no_done: got %0d pulses want 0", ndone); end
    endtask

    task automatic test_asr_max();
        int cyc; bit seen; exp_t e;
        for (int a = 1; a >= 0; a--) begin
            issue(64'h8000_0000_0000_0000, 63, a[0], 1'b0);
            wait_done(cyc, seen);
            e = sb.pop_front();
            total++; if (!seen || cyc != 17) begin bad++; $display("FAIL max_lat arith=%0d: got %0d want 17", a, cyc); end
            total++; if (bus.out !== e.res) begin bad++; $display("FAIL max_out arith=%0d: got %h want %h", a, bus.out, e.res); end
            tick();
        end
    endtask

    task automatic test_zero_nonmult();
        int cyc; bit seen; exp_t e;
        int sh_tab[2] = '{0, 5};
        foreach (sh_tab[i]) begin
            issue(64'h1234, sh_tab[i], 1'b0, 1'b0);
            wait_done(cyc, seen);
            e = sb.pop_front();
            total++; if (!seen || cyc != e.lat) begin bad++; $display("FAIL zn_lat sh=%0d: got %0d want %0d", sh_tab[i], cyc, e.lat); end
            total++; if (bus.out !== e.res) begin bad++; $display("FAIL zn_out sh=%0d: got %h want %h", sh_tab[i], bus.out, e.res); end
            tick();
        end
    endtask

    task automatic test_ignored_start();
        int cyc; bit seen; exp_t e;
        issue(64'hA5A5_5A5A_0F0F_F0F0, 8, 1'b0, 1'b1);
        wait_done(cyc, seen);
        e = sb.pop_front();
        total++; if (!seen || cyc != 3) begin bad++; $display("FAIL hold_lat: got %0d want 3", cyc); end
        total++; if (bus.out !== e.res) begin bad++; $display("FAIL hold_out: got %h want %h", bus.out, e.res); end
        // start still high across the done cycle must not be taken
        tick();
        bus.start = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL hold_done_cycle_start: busy %b want 0", bus.busy); end
        tick();
        total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++; $display("FAIL hold_idle: busy %b done %b want 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_capture();
        int cyc; bit seen; exp_t e;
        issue(64'hF0F0_1234_5678_9ABC, 12, 1'b1, 1'b0);
        bus.in    = 64'h0;
        bus.shamt = 6'd1;
        bus.arith = 1'b0;
        wait_done(cyc, seen);
        e = sb.pop_front();
        total++; if (!seen || cyc != e.lat) begin bad++; $display("FAIL cap_lat: got %0d want %0d", cyc, e.lat); end
        total++; if (bus.out !== e.res) begin bad++; $display("FAIL cap_out: got %h want %h", bus.out, e.res); end
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc; bit seen; exp_t e;
        logic [63:0] first;
        issue(64'hDEAD_BEEF_0000_0000, 16, 1'b0, 1'b0);
        wait_done(cyc, seen);
        e = sb.pop_front();
        first = e.res;
        total++; if (bus.out !== first) begin bad++; $display("FAIL b2b_out1: got %h want %h", bus.out, first); end
        tick();
        issue(64'h8000_0000_0000_FF00, 7, 1'b1, 1'b0);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_accept: busy %b want 1", bus.busy); end
        tick();
        total++; if (bus.out !== first) begin bad++; $display("FAIL b2b_hold: got %h want %h", bus.out, first); end
        wait_done(cyc, seen);
        e = sb.pop_front();
        total++; if (!seen || cyc != e.lat - 1) begin bad++; $display("FAIL b2b_lat: got %0d want %0d", cyc + 1, e.lat); end
        total++; if (bus.out !== e.res) begin bad++; $display("FAIL b2b_out2: got %h want %h", bus.out, e.res); end
        tick();
    endtask

    initial begin
        test_reset();
        test_lsr();
        test_reset_mid();
        test_asr_max();
        test_zero_nonmult();
        test_ignored_start();
        test_capture();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
